pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline-stage register with valid/ready handshake, optional skid entry and flush.
//  Next generation of the single-bit load-enable flop: n-bit datapath, back-pressure, bubble insertion.
//  Sits between RISC-V pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries the stage payload and injects a NOP/bubble on flush (branch mispredict, trap).
// PARAMETERS
//  WIDTH       32            payload width in bits (>=1)
//  RST_VAL     0             out_data value after reset (WIDTH bits)
//  BUBBLE_VAL  32'h00000013  out_data value after flush (ADDI x0,x0,0); truncated/zero-extended to WIDTH
//  SKID        1             1: two-entry skid buffer, registered in_ready; 0: single entry, ready passthrough
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  flush      in   1      synchronous flush; empties stage, loads BUBBLE_VAL
//  in_valid   in   1      upstream payload valid
//  in_ready   out  1      stage can accept this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds a valid payload
//  out_ready  in   1      downstream accepts this cycle
//  out_data   out  WIDTH  payload to next stage
//  level      out  2      occupied entries: 0, 1 or 2 (2 only when SKID=1)
// BEHAVIOUR
//  Reset (async, any time, overrides all): out_valid=0, out_data=RST_VAL, skid cleared, level=0,
//   in_ready=1. Mid-operation reset discards all held payloads immediately.
//  Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready; both sampled at posedge clk.
//  Latency 1 cycle, accept -> out_valid. Throughput 1 payload/cycle when out_ready is held high.
//  out_data/out_valid are registered and stable while out_valid & !out_ready; no combinational in->out path.
//  States: EMPTY (level 0), ONE (main valid), FULL (main + skid valid, SKID=1 only).
//  SKID=1 transitions; in_ready = (state != FULL), from state register only:
//   EMPTY: accept -> ONE, main<=in_data
//   ONE: accept & !drain -> FULL, skid<=in_data | accept & drain -> ONE, main<=in_data
//        drain & !accept -> EMPTY | neither -> hold
//   FULL: drain -> ONE, main<=skid | else hold; no accept possible
//  SKID=0: in_ready = !out_valid | out_ready (combinational). States EMPTY/ONE only.
//   Behaviour otherwise as EMPTY/ONE above.
//  EMPTY holds out_data at its last value (RST_VAL, BUBBLE_VAL or last drained payload).
//  flush priority: rst > flush > drain/accept.
//   flush: next state EMPTY, main<=BUBBLE_VAL, skid discarded, out_valid=0, level=0.
//   A same-cycle accept is dropped; a same-cycle drain still counts downstream.
//   in_ready remains as computed during flush (upstream may see its beat dropped).
//  Unused in_data when !accept is ignored. X on in_data with in_valid=0 never propagates to out_data.
// STRUCTURE
//  Include pipe_defs.vh: state codes ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2; RV_NOP=32'h00000013.
//  Sub-module en_reg #(WIDTH, RST_VAL): n-bit async-reset, load-enable register.
//   q<=RST_VAL on rst, else q<=d when en.
//   Instantiated for main and skid entries; the skid instance is generated only when SKID=1.
//  Top-level holds the 2-bit state register, enable/mux select logic and the level decode.
// TESTING
//  Reset: rst=1 mid-FULL -> same cycle out_valid=0, out_data=RST_VAL, level=0, in_ready=1.
//  Streaming: in_valid=1, out_ready=1, data 1,2,3,4 -> out 1,2,3,4 one cycle later, 1/cycle, level=1.
//  Back-pressure SKID=1: push 0xA,0xB with out_ready=0 -> level=2, in_ready=0, out_data=0xA stable.
//   Then out_ready=1 -> drains 0xA then 0xB.
//  SKID=0 stall: out_ready=0 with ONE -> in_ready=0 same cycle.
//   Raise out_ready with in_valid=1 -> drain and accept in the same cycle.
//  Flush: FULL(0xA,0xB) + flush + in_valid(0xC) -> next cycle out_valid=0, out_data=0x00000013, level=0.
//   0xC is never output.
//  Random: valid/ready toggled at 50% for 10k cycles vs scoreboard -> no loss, duplication or reorder.
//   out_data stable while stalled.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg
//   Shared definitions for the pipeline-stage register: FSM state codes,
//   main-entry load source select and the RISC-V NOP used as the bubble.
//   No ports.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_IN     = 2'd0,
    SRC_SKID   = 2'd1,
    SRC_BUBBLE = 2'd2
  } main_src_t;

  // ADDI x0,x0,0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_reg_en_reg.sv
// en_reg
//   n-bit register with asynchronous active-high reset and load enable.
// Ports
//   clk  in  1      clock, rising edge
//   rst  in  1      async reset, loads RST_VAL
//   en   in  1      load enable
//   d    in  WIDTH  next value
//   q    out WIDTH  registered value
module en_reg #(
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
//   Pipeline-stage register with valid/ready handshake, optional skid entry
//   and a flush that empties the stage and loads a bubble (NOP) payload.
//   out_valid/out_data are purely registered; with SKID=1 in_ready is also
//   derived from the state register only.
// Ports
//   clk       in  1      clock, rising edge
//   rst       in  1      async reset, active-high
//   flush     in  1      sync flush: empty stage, out_data <= BUBBLE_VAL
//   in_valid  in  1      upstream payload valid
//   in_ready  out 1      stage can accept this cycle
//   in_data   in  WIDTH  upstream payload
//   out_valid out 1      out_data holds a valid payload
//   out_ready in  1      downstream accepts this cycle
//   out_data  out WIDTH  payload to next stage
//   level     out 2      occupied entries (0..2)
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no payload; out_data holds its last value
// ST_ONE   | main entry valid, skid empty
// ST_FULL  | main and skid valid, in_ready low (SKID=1 only)
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter logic [31:0]      BUBBLE_VAL = RV_NOP,
  parameter bit               SKID       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE_VAL);

  state_t           state_q, state_d;
  main_src_t        main_src;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, main_q, skid_q;
  logic             accept, drain;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign level     = state_q;

  generate
    if (SKID) begin : g_ready_reg
      assign in_ready = (state_q != ST_FULL);
    end else begin : g_ready_pass
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    main_en  = 1'b0;
    main_src = SRC_IN;
    skid_en  = 1'b0;
    if (flush) begin
      // Same-cycle accept is dropped; skid contents are simply abandoned.
      state_d  = ST_EMPTY;
      main_en  = 1'b1;
      main_src = SRC_BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_en = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_en = 1'b1;
          end else if (accept) begin
            // Only reachable with SKID=1; without skid in_ready is low here.
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d  = ST_ONE;
            main_en  = 1'b1;
            main_src = SRC_SKID;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    case (main_src)
      SRC_SKID:   main_d = skid_q;
      SRC_BUBBLE: main_d = BUBBLE_W;
      default:    main_d = in_data;
    endcase
  end

  en_reg #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  generate
    if (SKID) begin : g_skid
      en_reg #(.WIDTH(WIDTH), .RST_VAL('0)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg
//   Two instances driven by the same stimulus: index 1 has SKID=1, index 0
//   has SKID=0. Each is compared every cycle against a FIFO-style model of
//   the stage (ordered list of held payloads plus last shown value).
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam int          W   = 32;
  localparam logic [W-1:0] RV1 = 32'h5A5A_0001;
  localparam logic [W-1:0] RV0 = 32'h0000_0000;
  localparam logic [W-1:0] BUB = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         ir [2];
  logic         ov [2];
  logic [W-1:0] od [2];
  logic [1:0]   lv [2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .RST_VAL(RV1), .BUBBLE_VAL(32'h0000_0013), .SKID(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .level(lv[1])
  );

  pipe_stage_reg #(.WIDTH(W), .RST_VAL(RV0), .BUBBLE_VAL(32'h0000_0013), .SKID(1'b0)) dut_pass (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .level(lv[0])
  );

  logic [W-1:0] mq   [2][3];
  int           cnt  [2];
  logic [W-1:0] hold [2];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_ready(input int k);
    if (k == 1) return (cnt[k] < 2);
    return (cnt[k] == 0) || (out_ready === 1'b1);
  endfunction

  task automatic model_reset();
    cnt[0] = 0; cnt[1] = 0;
    hold[0] = RV0; hold[1] = RV1;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_rdy%0d", tag, k), {63'd0, ir[k]}, {63'd0, exp_ready(k)});
      check($sformatf("%s_vld%0d", tag, k), {63'd0, ov[k]}, {63'd0, cnt[k] > 0});
      check($sformatf("%s_dat%0d", tag, k), {32'd0, od[k]}, {32'd0, (cnt[k] > 0) ? mq[k][0] : hold[k]});
      check($sformatf("%s_lvl%0d", tag, k), {62'd0, lv[k]}, 64'(cnt[k]));
    end
  endtask

  // One clock: check outputs at negedge, advance the model, return at posedge+1.
  task automatic step(input string tag);
    logic acc, drn;
    @(negedge clk);
    check_model(tag);
    for (int k = 0; k < 2; k++) begin
      acc = in_valid && exp_ready(k);
      drn = (cnt[k] > 0) && out_ready;
      if (flush) begin
        cnt[k]  = 0;
        hold[k] = BUB;
      end else begin
        if (drn) begin
          if (cnt[k] == 1) hold[k] = mq[k][0];
          mq[k][0] = mq[k][1];
          mq[k][1] = mq[k][2];
          cnt[k]--;
        end
        if (acc) begin
          mq[k][cnt[k]] = in_data;
          cnt[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) begin
      check("reset_vld", {63'd0, ov[k]}, 64'd0);
      check("reset_lvl", {62'd0, lv[k]}, 64'd0);
      check("reset_rdy", {63'd0, ir[k]}, 64'd1);
    end
    check("reset_dat1", {32'd0, od[1]}, {32'd0, RV1});
    check("reset_dat0", {32'd0, od[0]}, {32'd0, RV0});
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // streaming 1,2,3,4 with out_ready high
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      step("stream");
      check("stream_dat1", {32'd0, od[1]}, 64'(i));
      check("stream_dat0", {32'd0, od[0]}, 64'(i));
      check("stream_lvl1", {62'd0, lv[1]}, 64'd1);
    end
    in_valid = 1'b0;
    step("stream_end");

    // back-pressure: 0xA, 0xB with out_ready low
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; step("bp");
    in_data = 32'hB; step("bp");
    check("bp_lvl1", {62'd0, lv[1]}, 64'd2);
    check("bp_rdy1", {63'd0, ir[1]}, 64'd0);
    check("bp_dat1", {32'd0, od[1]}, 64'hA);
    check("stall_rdy0", {63'd0, ir[0]}, 64'd0);
    in_valid = 1'b0; in_data = 32'hFFFF_FFFF;
    step("bp_hold");
    check("bp_stable1", {32'd0, od[1]}, 64'hA);
    out_ready = 1'b1;
    step("bp_drain");
    check("bp_drainB", {32'd0, od[1]}, 64'hB);
    step("bp_drain");
    check("bp_empty1", {63'd0, ov[1]}, 64'd0);

    // SKID=0: stall then drain+accept in one cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step("s0");
    in_data = 32'h22; #1;
    check("s0_stall_rdy", {63'd0, ir[0]}, 64'd0);
    step("s0");
    out_ready = 1'b1; in_data = 32'h33; #1;
    check("s0_pass_rdy", {63'd0, ir[0]}, 64'd1);
    step("s0");
    check("s0_dat", {32'd0, od[0]}, 64'h33);
    check("s0_lvl", {62'd0, lv[0]}, 64'd1);
    in_valid = 1'b0;
    step("s0_drain"); step("s0_drain"); step("s0_drain");

    // flush while FULL with a concurrent beat 0xC
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA; step("fl");
    in_data = 32'hB; step("fl");
    flush = 1'b1; in_data = 32'hC; step("fl");
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("flush_vld", {63'd0, ov[k]}, 64'd0);
      check("flush_dat", {32'd0, od[k]}, 64'h13);
      check("flush_lvl", {62'd0, lv[k]}, 64'd0);
    end
    out_ready = 1'b1;
    step("fl_after"); step("fl_after");

    // X on in_data while not valid must not reach out_data
    in_valid = 1'b0; in_data = 'x;
    step("xin"); step("xin");
    in_data = '0;

    // randomized traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      flush     = ($urandom_range(0, 31) == 0);
      step("rand");
    end
    flush = 1'b0;

    // async reset mid-FULL
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'h77; step("pre_rst");
    in_data = 32'h88; step("pre_rst");
    check("pre_rst_lvl1", {62'd0, lv[1]}, 64'd2);
    #2; rst = 1'b1; #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      check("arst_vld", {63'd0, ov[k]}, 64'd0);
      check("arst_lvl", {62'd0, lv[k]}, 64'd0);
      check("arst_rdy", {63'd0, ir[k]}, 64'd1);
    end
    check("arst_dat1", {32'd0, od[1]}, {32'd0, RV1});
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h99;
    step("post_rst");
    in_valid = 1'b0;
    step("post_rst"); step("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
